// File: rtl/police_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : police_dispatch
// Purpose  : Police-response controller. Latches the corpse position when a
//            discovery is reported, drives the police car in from off-screen,
//            walks an officer to the corpse and back, then drives the car off.
// Ports    : Clk, Reset (async, active-high)
//            frame_tick        - one-cycle pulse per video frame (motion gate)
//            corpse_discovered - discovery level, honoured only when idle
//            death_X/death_Y   - corpse position, sampled on acceptance
//            police_car_X/Y    - car centre
//            police_X/Y        - officer centre
//            police_out        - officer on foot
//            reached           - officer back in car (sticky)
//            collected         - corpse removed (sticky)
// Revision : 1.0 - initial release
// ============================================================================
module police_dispatch #(
    parameter logic [9:0] CAR_START_X    = 10'd700,
    parameter logic [9:0] CAR_STOP_X     = 10'd560,
    parameter logic [9:0] CAR_Y          = 10'd440,
    parameter logic [9:0] CAR_STEP       = 10'd2,
    parameter logic [9:0] WALK_STEP      = 10'd1,
    parameter logic [7:0] COLLECT_FRAMES = 8'd60
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic       corpse_discovered,
    input  logic [9:0] death_X,
    input  logic [9:0] death_Y,
    output logic [9:0] police_car_X,
    output logic [9:0] police_car_Y,
    output logic [9:0] police_X,
    output logic [9:0] police_Y,
    output logic       police_out,
    output logic       reached,
    output logic       collected
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_DRIVE_IN  = 3'd1,
        S_EXIT      = 3'd2,
        S_WALK_TO   = 3'd3,
        S_COLLECT   = 3'd4,
        S_WALK_BACK = 3'd5,
        S_DRIVE_OUT = 3'd6,
        S_DONE      = 3'd7
    } state_t;

    state_t     r_state;
    logic [9:0] r_tgt_X;
    logic [9:0] r_tgt_Y;
    logic [7:0] r_cnt;

    // Move pos toward tgt by at most stp; compares come first so the
    // unsigned subtraction never wraps and the result never overshoots.
    function automatic logic [9:0] f_step_toward(input logic [9:0] pos,
                                                 input logic [9:0] tgt,
                                                 input logic [9:0] stp);
        logic [9:0] v_res;
        v_res = pos;
        if (pos < tgt)
            v_res = ((tgt - pos) > stp) ? (pos + stp) : tgt;
        else if (pos > tgt)
            v_res = ((pos - tgt) > stp) ? (pos - stp) : tgt;
        return v_res;
    endfunction

    logic [9:0] w_car_in_step;
    logic [9:0] w_car_out_step;
    logic [9:0] w_car_in_next;
    logic [9:0] w_car_out_next;
    logic [9:0] w_to_x;
    logic [9:0] w_to_y;
    logic [9:0] w_back_x;
    logic [9:0] w_back_y;
    logic       w_at_tgt;
    logic       w_at_car;

    // Saturating car steps toward the stop / start positions.
    assign w_car_in_step  = ((police_car_X > CAR_STOP_X) &&
                             ((police_car_X - CAR_STOP_X) > CAR_STEP))
                            ? (police_car_X - CAR_STEP) : CAR_STOP_X;
    assign w_car_out_step = ((police_car_X < CAR_START_X) &&
                             ((CAR_START_X - police_car_X) > CAR_STEP))
                            ? (police_car_X + CAR_STEP) : CAR_START_X;

    // Value the car will hold after this edge; lets the arrival transition
    // happen on the same edge as the final step.
    assign w_car_in_next  = frame_tick ? w_car_in_step  : police_car_X;
    assign w_car_out_next = frame_tick ? w_car_out_step : police_car_X;

    assign w_to_x   = f_step_toward(police_X, r_tgt_X, WALK_STEP);
    assign w_to_y   = f_step_toward(police_Y, r_tgt_Y, WALK_STEP);
    assign w_back_x = f_step_toward(police_X, police_car_X, WALK_STEP);
    assign w_back_y = f_step_toward(police_Y, CAR_Y, WALK_STEP);

    assign w_at_tgt = (police_X == r_tgt_X) && (police_Y == r_tgt_Y);
    assign w_at_car = (police_X == police_car_X) && (police_Y == CAR_Y);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state      <= S_IDLE;
            police_car_X <= CAR_START_X;
            police_car_Y <= CAR_Y;
            police_X     <= CAR_STOP_X;
            police_Y     <= CAR_Y;
            police_out   <= 1'b0;
            reached      <= 1'b0;
            collected    <= 1'b0;
            r_tgt_X      <= 10'd0;
            r_tgt_Y      <= 10'd0;
            r_cnt        <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (corpse_discovered) begin
                        r_tgt_X <= death_X;
                        r_tgt_Y <= death_Y;
                        r_state <= S_DRIVE_IN;
                    end
                end

                S_DRIVE_IN: begin
                    police_car_X <= w_car_in_next;
                    if (w_car_in_next == CAR_STOP_X)
                        r_state <= S_EXIT;
                end

                S_EXIT: begin
                    police_X   <= police_car_X;
                    police_Y   <= CAR_Y;
                    police_out <= 1'b1;
                    r_state    <= S_WALK_TO;
                end

                S_WALK_TO: begin
                    // Arrival is checked every cycle, so a target at the
                    // spawn point costs one cycle and no ticks.
                    if (w_at_tgt) begin
                        r_state <= S_COLLECT;
                    end else if (frame_tick) begin
                        police_X <= w_to_x;
                        police_Y <= w_to_y;
                    end
                end

                S_COLLECT: begin
                    if (frame_tick) begin
                        if ((r_cnt + 8'd1) == COLLECT_FRAMES) begin
                            collected <= 1'b1;
                            r_cnt     <= 8'd0;
                            r_state   <= S_WALK_BACK;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                end

                S_WALK_BACK: begin
                    if (w_at_car) begin
                        police_out <= 1'b0;
                        reached    <= 1'b1;
                        r_state    <= S_DRIVE_OUT;
                    end else if (frame_tick) begin
                        police_X <= w_back_x;
                        police_Y <= w_back_y;
                    end
                end

                S_DRIVE_OUT: begin
                    police_car_X <= w_car_out_next;
                    if (w_car_out_next == CAR_START_X)
                        r_state <= S_DONE;
                end

                default: begin
                    // S_DONE: hold everything until Reset.
                    r_state <= r_state;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_police_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : tb_police_dispatch
// Purpose  : Self-checking bench for police_dispatch. Each dispatch pushes its
//            expected event sequence (event kind + tick offset) into a
//            scoreboard queue; a monitor pops and compares as events appear.
// Revision : 1.0 - initial release
// ============================================================================
module tb_police_dispatch;

    localparam int E_CAR   = 0;  // car reaches stop X
    localparam int E_OUT   = 1;  // officer leaves car
    localparam int E_XARR  = 2;  // officer X reaches target X
    localparam int E_ARR   = 3;  // officer reaches target
    localparam int E_COLL  = 4;  // collected rises
    localparam int E_REACH = 5;  // reached rises
    localparam int E_DONE  = 6;  // car back at start X

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_tick = 1'b0;
    logic       corpse_discovered;
    logic [9:0] death_X;
    logic [9:0] death_Y;
    logic [9:0] police_car_X;
    logic [9:0] police_car_Y;
    logic [9:0] police_X;
    logic [9:0] police_Y;
    logic       police_out;
    logic       reached;
    logic       collected;

    police_dispatch u_dut (
        .Clk               (Clk),
        .Reset             (Reset),
        .frame_tick        (frame_tick),
        .corpse_discovered (corpse_discovered),
        .death_X           (death_X),
        .death_Y           (death_Y),
        .police_car_X      (police_car_X),
        .police_car_Y      (police_car_Y),
        .police_X          (police_X),
        .police_Y          (police_Y),
        .police_out        (police_out),
        .reached           (reached),
        .collected         (collected)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int kind;
        int tick;
    } ev_t;

    ev_t sb[$];
    int  n_total = 0;
    int  n_bad   = 0;
    int  tick_cnt = 0;
    int  tick_base = 0;
    bit  tick_en = 1'b0;
    int  exp_tx = 560;
    int  exp_ty = 440;

    task automatic chk(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic fire(input int kind);
        ev_t e;
        if (sb.size() == 0) begin
            chk($sformatf("unexpected_ev%0d", kind), kind, -1);
        end else begin
            e = sb.pop_front();
            chk("ev_kind", kind, e.kind);
            chk($sformatf("ev%0d_tick", e.kind), tick_cnt - tick_base, e.tick);
        end
    endtask

    // Monitor then tick generator, in one process so their order per falling
    // edge is fixed.
    initial begin : p_mon_gen
        int  prev_car = 700;
        bit  prev_out = 0, prev_coll = 0, prev_reach = 0;
        bit  xarm = 0, aarm = 0, range_bad = 0;
        int  phase = 0;
        int  lo_x, hi_x, lo_y, hi_y;
        forever begin
            @(negedge Clk);
            if (Reset) begin
                xarm = 0;
                aarm = 0;
            end else begin
                if (police_car_X == 10'd560 && prev_car != 560) fire(E_CAR);
                if (police_out && !prev_out) begin
                    fire(E_OUT);
                    xarm = 1;
                    aarm = 1;
                    range_bad = 0;
                end
                if (police_out) begin
                    lo_x = (exp_tx < 560) ? exp_tx : 560;
                    hi_x = (exp_tx < 560) ? 560 : exp_tx;
                    lo_y = (exp_ty < 440) ? exp_ty : 440;
                    hi_y = (exp_ty < 440) ? 440 : exp_ty;
                    if (int'(police_X) < lo_x || int'(police_X) > hi_x ||
                        int'(police_Y) < lo_y || int'(police_Y) > hi_y)
                        range_bad = 1;
                end
                if (xarm && police_out && int'(police_X) == exp_tx) begin
                    fire(E_XARR);
                    xarm = 0;
                end
                if (aarm && police_out && int'(police_X) == exp_tx &&
                    int'(police_Y) == exp_ty) begin
                    fire(E_ARR);
                    aarm = 0;
                    chk("no_overshoot", int'(range_bad), 0);
                end
                if (collected && !prev_coll) fire(E_COLL);
                if (reached && !prev_reach) begin
                    fire(E_REACH);
                    chk("reach_out", int'(police_out), 0);
                    chk("reach_x", int'(police_X), 560);
                    chk("reach_y", int'(police_Y), 440);
                end
                if (police_car_X == 10'd700 && prev_car != 700) fire(E_DONE);
            end
            prev_car   = int'(police_car_X);
            prev_out   = police_out;
            prev_coll  = collected;
            prev_reach = reached;

            if (tick_en) begin
                phase++;
                if (phase % 4 == 0) begin
                    frame_tick = 1'b1;
                    tick_cnt++;
                end else begin
                    frame_tick = 1'b0;
                end
            end else begin
                frame_tick = 1'b0;
            end
        end
    end

    task automatic check_reset_vals(input string pfx);
        chk({pfx, "_car_x"}, int'(police_car_X), 700);
        chk({pfx, "_car_y"}, int'(police_car_Y), 440);
        chk({pfx, "_pol_x"}, int'(police_X), 560);
        chk({pfx, "_pol_y"}, int'(police_Y), 440);
        chk({pfx, "_out"}, int'(police_out), 0);
        chk({pfx, "_reached"}, int'(reached), 0);
        chk({pfx, "_collected"}, int'(collected), 0);
    endtask

    task automatic do_reset();
        @(posedge Clk);
        #1;
        tick_en = 1'b0;
        Reset = 1'b1;
        sb.delete();
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;
    endtask

    task automatic dispatch(input int x, input int y, input bit en);
        int dx, dy, w;
        ev_t e;
        @(posedge Clk);
        #1;
        tick_en = 1'b0;
        death_X = 10'(x);
        death_Y = 10'(y);
        corpse_discovered = 1'b1;
        @(posedge Clk);
        #1;
        corpse_discovered = 1'b0;
        tick_base = tick_cnt;
        exp_tx = x;
        exp_ty = y;
        dx = (x > 560) ? x - 560 : 560 - x;
        dy = (y > 440) ? y - 440 : 440 - y;
        w  = (dx > dy) ? dx : dy;
        if (en) begin
            e.kind = E_CAR;   e.tick = 70;              sb.push_back(e);
            e.kind = E_OUT;   e.tick = 70;              sb.push_back(e);
            e.kind = E_XARR;  e.tick = 70 + dx;         sb.push_back(e);
            e.kind = E_ARR;   e.tick = 70 + w;          sb.push_back(e);
            e.kind = E_COLL;  e.tick = 130 + w;         sb.push_back(e);
            e.kind = E_REACH; e.tick = 130 + 2 * w;     sb.push_back(e);
            e.kind = E_DONE;  e.tick = 200 + 2 * w;     sb.push_back(e);
        end
        tick_en = en;
    endtask

    task automatic wait_sb_empty(input int max_cyc);
        int c = 0;
        while (sb.size() != 0 && c < max_cyc) begin
            @(posedge Clk);
            c++;
        end
        #1;
        if (sb.size() != 0) chk("sb_drain_timeout", sb.size(), 0);
    endtask

    task automatic wait_ticks(input int n, input int max_cyc);
        int c = 0;
        while ((tick_cnt - tick_base) < n && c < max_cyc) begin
            @(posedge Clk);
            c++;
        end
        @(posedge Clk);
        #1;
        if ((tick_cnt - tick_base) < n) chk("tick_wait_timeout", tick_cnt - tick_base, n);
    endtask

    task automatic check_done_hold();
        repeat (20) @(posedge Clk);
        #1;
        chk("hold_car_x", int'(police_car_X), 700);
        chk("hold_reached", int'(reached), 1);
        chk("hold_collected", int'(collected), 1);
        chk("hold_out", int'(police_out), 0);
    endtask

    initial begin
        Reset = 1'b1;
        corpse_discovered = 1'b0;
        death_X = 10'd0;
        death_Y = 10'd0;
        repeat (3) @(posedge Clk);
        #1;
        check_reset_vals("rst");
        Reset = 1'b0;

        // Main dispatch with a second discovery pulse mid-walk.
        dispatch(400, 250, 1'b1);
        wait_ticks(150, 1000);
        chk("mid_walk_out", int'(police_out), 1);
        death_X = 10'd100;
        death_Y = 10'd100;
        corpse_discovered = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        corpse_discovered = 1'b0;
        wait_sb_empty(4000);
        check_done_hold();

        // Target at the spawn point.
        do_reset();
        dispatch(560, 440, 1'b1);
        wait_sb_empty(2000);
        check_done_hold();

        // Diagonal walk with X saturating early.
        do_reset();
        dispatch(555, 300, 1'b1);
        wait_sb_empty(3000);

        // No frame ticks: everything stays frozen.
        do_reset();
        dispatch(400, 250, 1'b0);
        repeat (200) @(posedge Clk);
        #1;
        chk("frozen_car_x", int'(police_car_X), 700);
        chk("frozen_out", int'(police_out), 0);
        chk("frozen_pol_x", int'(police_X), 560);

        // Asynchronous reset during COLLECT, then a fresh dispatch.
        do_reset();
        dispatch(560, 440, 1'b1);
        wait_ticks(100, 1000);
        chk("precoll_out", int'(police_out), 1);
        chk("precoll_collected", int'(collected), 0);
        #1;
        Reset = 1'b1;
        tick_en = 1'b0;
        #1;
        check_reset_vals("async");
        sb.delete();
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;
        dispatch(560, 440, 1'b1);
        wait_sb_empty(2000);
        check_done_hold();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
